// File: rtl/sc_matrix_max7219_scanout.sv
//==============================================================================
// Module      : sc_matrix_max7219_scanout
// Description : Snapshots eight 8-bit playfield rows and serializes them to a
//               MAX7219 8x8 LED driver (DIN/SCLK/LOAD), after a one-shot init.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sc_matrix_max7219_scanout #(
    parameter int         CLKDIV_HALF = 4,
    parameter logic [3:0] INTENSITY   = 4'h8
) (
    input  logic        SC_MATRIXSCAN_CLOCK_50,
    input  logic        SC_MATRIXSCAN_RESET_InHigh,
    input  logic        SC_MATRIXSCAN_start_InLow,
    input  logic [63:0] SC_MATRIXSCAN_rows_InBUS,
    output logic        SC_MATRIXSCAN_DIN_Out,
    output logic        SC_MATRIXSCAN_SCLK_Out,
    output logic        SC_MATRIXSCAN_LOAD_Out,
    output logic        SC_MATRIXSCAN_busy_Out,
    output logic        SC_MATRIXSCAN_done_Out
);

    localparam int               c_DIV_W      = (CLKDIV_HALF > 1) ? $clog2(CLKDIV_HALF) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLKDIV_HALF - 1);
    localparam logic [2:0]       c_INIT_LAST  = 3'd4;
    localparam logic [2:0]       c_FRAME_LAST = 3'd7;

    typedef enum logic [2:0] {
        ST_INIT_LOW  = 3'd0,
        ST_INIT_HIGH = 3'd1,
        ST_INIT_GAP  = 3'd2,
        ST_IDLE      = 3'd3,
        ST_LOW       = 3'd4,
        ST_HIGH      = 3'd5,
        ST_GAP       = 3'd6
    } state_t;

    state_t               r_state;
    logic                 r_armed;
    logic [2:0]           r_word;
    logic [3:0]           r_bit;
    logic [c_DIV_W-1:0]   r_div;
    logic [63:0]          r_snap;
    logic                 r_din;
    logic                 r_sclk;
    logic                 r_load;
    logic                 r_busy;
    logic                 r_done;

    state_t               w_nextState;
    logic [2:0]           w_nextWord;
    logic [3:0]           w_nextBit;
    logic [c_DIV_W-1:0]   w_nextDiv;
    logic                 w_divWrap;
    logic                 w_accept;
    logic                 w_frameEnd;
    logic [63:0]          w_snapNext;
    logic [15:0]          w_wordVal;
    logic                 w_inInit;
    logic                 w_shifting;

    assign w_divWrap  = (r_div == c_DIV_LAST);
    assign w_snapNext = w_accept ? SC_MATRIXSCAN_rows_InBUS : r_snap;

    // Bit engine shared by init and frame; r_armed holds off the first word
    // until the first edge after reset release.
    always_comb begin
        w_nextState = r_state;
        w_nextWord  = r_word;
        w_nextBit   = r_bit;
        w_nextDiv   = r_div;
        w_accept    = 1'b0;
        w_frameEnd  = 1'b0;
        if (!r_armed) begin
            w_nextState = ST_INIT_LOW;
            w_nextWord  = 3'd0;
            w_nextBit   = 4'd15;
            w_nextDiv   = '0;
        end else begin
            case (r_state)
                ST_INIT_LOW, ST_LOW: begin
                    if (w_divWrap) begin
                        w_nextDiv   = '0;
                        w_nextState = (r_state == ST_INIT_LOW) ? ST_INIT_HIGH : ST_HIGH;
                    end else begin
                        w_nextDiv = r_div + 1'b1;
                    end
                end
                ST_INIT_HIGH, ST_HIGH: begin
                    if (w_divWrap) begin
                        w_nextDiv = '0;
                        if (r_bit == 4'd0) begin
                            w_nextState = (r_state == ST_INIT_HIGH) ? ST_INIT_GAP : ST_GAP;
                        end else begin
                            w_nextBit   = r_bit - 4'd1;
                            w_nextState = (r_state == ST_INIT_HIGH) ? ST_INIT_LOW : ST_LOW;
                        end
                    end else begin
                        w_nextDiv = r_div + 1'b1;
                    end
                end
                ST_INIT_GAP: begin
                    if (w_divWrap) begin
                        w_nextDiv = '0;
                        if (r_word == c_INIT_LAST) begin
                            w_nextState = ST_IDLE;
                        end else begin
                            w_nextWord  = r_word + 3'd1;
                            w_nextBit   = 4'd15;
                            w_nextState = ST_INIT_LOW;
                        end
                    end else begin
                        w_nextDiv = r_div + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_divWrap) begin
                        w_nextDiv = '0;
                        if (r_word == c_FRAME_LAST) begin
                            w_nextState = ST_IDLE;
                            w_frameEnd  = 1'b1;
                        end else begin
                            w_nextWord  = r_word + 3'd1;
                            w_nextBit   = 4'd15;
                            w_nextState = ST_LOW;
                        end
                    end else begin
                        w_nextDiv = r_div + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (!SC_MATRIXSCAN_start_InLow) begin
                        w_accept    = 1'b1;
                        w_nextState = ST_LOW;
                        w_nextWord  = 3'd0;
                        w_nextBit   = 4'd15;
                        w_nextDiv   = '0;
                    end
                end
                default: begin
                    w_nextState = ST_IDLE;
                end
            endcase
        end
    end

    assign w_inInit   = (w_nextState == ST_INIT_LOW) || (w_nextState == ST_INIT_HIGH) ||
                        (w_nextState == ST_INIT_GAP);
    assign w_shifting = (w_nextState == ST_INIT_LOW) || (w_nextState == ST_INIT_HIGH) ||
                        (w_nextState == ST_LOW)      || (w_nextState == ST_HIGH);

    // Word about to be driven, so DIN is already valid on the first LOW cycle.
    always_comb begin
        w_wordVal = 16'h0000;
        if (w_inInit) begin
            case (w_nextWord)
                3'd0:    w_wordVal = 16'h0C01;
                3'd1:    w_wordVal = 16'h0B07;
                3'd2:    w_wordVal = 16'h0900;
                3'd3:    w_wordVal = {8'h0A, 4'h0, INTENSITY};
                default: w_wordVal = 16'h0F00;
            endcase
        end else begin
            w_wordVal = {4'h0, {1'b0, w_nextWord} + 4'd1, w_snapNext[{w_nextWord, 3'b000} +: 8]};
        end
    end

    always_ff @(posedge SC_MATRIXSCAN_CLOCK_50 or posedge SC_MATRIXSCAN_RESET_InHigh) begin
        if (SC_MATRIXSCAN_RESET_InHigh) begin
            r_state <= ST_INIT_LOW;
            r_armed <= 1'b0;
            r_word  <= 3'd0;
            r_bit   <= 4'd0;
            r_div   <= '0;
            r_snap  <= 64'd0;
            r_din   <= 1'b0;
            r_sclk  <= 1'b0;
            r_load  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_armed <= 1'b1;
            r_word  <= w_nextWord;
            r_bit   <= w_nextBit;
            r_div   <= w_nextDiv;
            r_snap  <= w_snapNext;
            r_din   <= w_shifting ? w_wordVal[w_nextBit] : 1'b0;
            r_sclk  <= (w_nextState == ST_INIT_HIGH) || (w_nextState == ST_HIGH);
            r_load  <= !w_shifting;
            r_busy  <= (w_nextState != ST_IDLE);
            r_done  <= w_frameEnd;
        end
    end

    assign SC_MATRIXSCAN_DIN_Out  = r_din;
    assign SC_MATRIXSCAN_SCLK_Out = r_sclk;
    assign SC_MATRIXSCAN_LOAD_Out = r_load;
    assign SC_MATRIXSCAN_busy_Out = r_busy;
    assign SC_MATRIXSCAN_done_Out = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sc_matrix_max7219_scanout.sv
// Testbench for sc_matrix_max7219_scanout: decodes the serial stream and
// compares it with words computed directly from the row values.
`timescale 1ns/1ps
`default_nettype none

module tb_sc_matrix_max7219_scanout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, startN;
    logic [63:0] rows;
    logic        din, sclk, load, busy, done;

    logic        rst3, startN3;
    logic [63:0] rows3;
    logic        din3, sclk3, load3, busy3, done3;

    int vectors = 0;
    int miscompares = 0;

    sc_matrix_max7219_scanout #(.CLKDIV_HALF(2), .INTENSITY(4'h8)) dut (
        .SC_MATRIXSCAN_CLOCK_50     (clk),
        .SC_MATRIXSCAN_RESET_InHigh (rst),
        .SC_MATRIXSCAN_start_InLow  (startN),
        .SC_MATRIXSCAN_rows_InBUS   (rows),
        .SC_MATRIXSCAN_DIN_Out      (din),
        .SC_MATRIXSCAN_SCLK_Out     (sclk),
        .SC_MATRIXSCAN_LOAD_Out     (load),
        .SC_MATRIXSCAN_busy_Out     (busy),
        .SC_MATRIXSCAN_done_Out     (done)
    );

    sc_matrix_max7219_scanout #(.CLKDIV_HALF(3), .INTENSITY(4'h8)) dut3 (
        .SC_MATRIXSCAN_CLOCK_50     (clk),
        .SC_MATRIXSCAN_RESET_InHigh (rst3),
        .SC_MATRIXSCAN_start_InLow  (startN3),
        .SC_MATRIXSCAN_rows_InBUS   (rows3),
        .SC_MATRIXSCAN_DIN_Out      (din3),
        .SC_MATRIXSCAN_SCLK_Out     (sclk3),
        .SC_MATRIXSCAN_LOAD_Out     (load3),
        .SC_MATRIXSCAN_busy_Out     (busy3),
        .SC_MATRIXSCAN_done_Out     (done3)
    );

    // Serial decoder: shift DIN on SCLK rise, emit a word when LOAD rises.
    logic [15:0] gotQ[$];
    logic [15:0] monShift = 16'h0;
    int          monCnt = 0;
    int          doneCnt = 0;
    logic        monPrevS = 1'b0;
    logic        monPrevL = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            monCnt   = 0;
            monPrevS = 1'b0;
            monPrevL = 1'b1;
        end else begin
            if (sclk && !monPrevS) begin
                monShift = {monShift[14:0], din};
                monCnt++;
            end
            if (load && !monPrevL) begin
                if (monCnt == 16) gotQ.push_back(monShift);
                monCnt = 0;
            end
            if (done) doneCnt++;
            monPrevS = sclk;
            monPrevL = load;
        end
    end

    function automatic logic [15:0] initWord(input int k);
        logic [15:0] tbl [5];
        tbl = '{16'h0C01, 16'h0B07, 16'h0900, 16'h0A08, 16'h0F00};
        return tbl[k];
    endfunction

    function automatic logic [15:0] frameWord(input logic [63:0] r, input int k);
        logic [7:0] addr;
        addr = 8'(k + 1);
        return {addr, r[8*k +: 8]};
    endfunction

    task automatic pulseStart();
        @(negedge clk); startN = 1'b0;
        @(negedge clk); startN = 1'b1;
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1; startN = 1'b1; rows = 64'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({din, sclk, load, busy, done} !== 5'b00100)
            $display("FAIL reset_outputs: got din/sclk/load/busy/done=%b want 00100", {din, sclk, load, busy, done});
        gotQ.delete(); doneCnt = 0;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, load, din, sclk} !== 4'b1000)
            $display("FAIL release_first_cycle: got busy/load/din/sclk=%b want 1000", {busy, load, din, sclk});
        cnt = 0;
        while (busy === 1'b1 && cnt < 2000) begin cnt++; @(negedge clk); end
        vectors++;
        if (cnt != 330) begin miscompares++; $display("FAIL init_busy_cycles: got %0d want 330", cnt); end
        vectors++;
        if (gotQ.size() != 5) begin miscompares++; $display("FAIL init_word_count: got %0d want 5", gotQ.size()); end
        for (int k = 0; k < 5 && k < gotQ.size(); k++) begin
            vectors++;
            if (gotQ[k] !== initWord(k)) begin
                miscompares++;
                $display("FAIL init_word%0d: got %h want %h", k, gotQ[k], initWord(k));
            end
        end
        vectors++;
        if (doneCnt != 0) begin miscompares++; $display("FAIL init_no_done: got %0d pulses want 0", doneCnt); end
    endtask

    task automatic test_frame(input logic [63:0] r);
        int cyc;
        rows = r; gotQ.delete(); doneCnt = 0;
        pulseStart();
        vectors++;
        if ({busy, load} !== 2'b10) begin
            miscompares++;
            $display("FAIL frame_first_cycle: got busy/load=%b want 10", {busy, load});
        end
        cyc = 1;
        while (done !== 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
        vectors++;
        if (cyc != 529) begin miscompares++; $display("FAIL frame_done_cycle: got N+%0d want N+529", cyc); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL frame_busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL frame_done_width: got %b want 0", done); end
        vectors++;
        if (gotQ.size() != 8) begin miscompares++; $display("FAIL frame_word_count: got %0d want 8", gotQ.size()); end
        for (int k = 0; k < 8 && k < gotQ.size(); k++) begin
            vectors++;
            if (gotQ[k] !== frameWord(r, k)) begin
                miscompares++;
                $display("FAIL frame_word%0d: got %h want %h", k, gotQ[k], frameWord(r, k));
            end
        end
    endtask

    task automatic test_snapshot();
        logic [63:0] r;
        int g;
        r = {$urandom, $urandom};
        rows = r; gotQ.delete();
        pulseStart();
        g = 0;
        while (gotQ.size() < 2 && g < 2000) begin @(negedge clk); g++; end
        rows = 64'd0;
        while (done !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL snapshot_timeout: done=%b want 1", done); end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (k >= gotQ.size() || gotQ[k] !== frameWord(r, k)) begin
                miscompares++;
                $display("FAIL snapshot_word%0d: got %h want %h", k,
                         (k < gotQ.size()) ? gotQ[k] : 16'hxxxx, frameWord(r, k));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b;
        int g;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        rows = a; gotQ.delete(); doneCnt = 0;
        @(negedge clk); startN = 1'b0;
        g = 0;
        @(negedge clk);
        while (done !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
        vectors++;
        if ({done, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_gap_cycle: got done/busy=%b want 10", {done, busy});
        end
        rows = b;
        @(negedge clk);
        vectors++;
        if ({done, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_restart: got done/busy=%b want 01", {done, busy});
        end
        startN = 1'b1;
        g = 0;
        while (done !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
        repeat (60) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || doneCnt != 2 || gotQ.size() != 16) begin
            miscompares++;
            $display("FAIL b2b_frames: got busy=%b done_pulses=%0d words=%0d want 0/2/16", busy, doneCnt, gotQ.size());
        end
        for (int k = 0; k < 16 && k < gotQ.size(); k++) begin
            vectors++;
            if (gotQ[k] !== frameWord((k < 8) ? a : b, k % 8)) begin
                miscompares++;
                $display("FAIL b2b_word%0d: got %h want %h", k, gotQ[k], frameWord((k < 8) ? a : b, k % 8));
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [63:0] r;
        int g;
        r = {$urandom, $urandom};
        rows = r; gotQ.delete(); doneCnt = 0;
        pulseStart();
        repeat (100) @(negedge clk);
        startN = 1'b0;
        @(negedge clk); startN = 1'b1;
        g = 0;
        while (done !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
        repeat (700) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || doneCnt != 1 || gotQ.size() != 8) begin
            miscompares++;
            $display("FAIL ignore_midframe_start: got busy=%b done_pulses=%0d words=%0d want 0/1/8", busy, doneCnt, gotQ.size());
        end
        vectors++;
        if (gotQ.size() < 8 || gotQ[7] !== frameWord(r, 7)) begin
            miscompares++;
            $display("FAIL ignore_last_word: got %h want %h", (gotQ.size() >= 8) ? gotQ[7] : 16'hxxxx, frameWord(r, 7));
        end
    endtask

    task automatic test_reset_midframe();
        int g;
        rows = {$urandom, $urandom}; gotQ.delete(); doneCnt = 0;
        pulseStart();
        g = 0;
        while (!(gotQ.size() == 3 && monCnt == 9) && g < 2000) begin @(negedge clk); #1; g++; end
        vectors++;
        if (g >= 2000) begin miscompares++; $display("FAIL midframe_reach_bit7: timeout waiting for word3 bit7"); end
        rst = 1'b1;
        #1;
        vectors++;
        if ({load, sclk, din, busy, done} !== 5'b10000) begin
            miscompares++;
            $display("FAIL midframe_async_reset: got load/sclk/din/busy/done=%b want 10000", {load, sclk, din, busy, done});
        end
        repeat (2) @(negedge clk);
        gotQ.delete();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        startN = 1'b0;
        @(negedge clk); startN = 1'b1;
        g = 0;
        while (busy === 1'b1 && g < 2000) begin @(negedge clk); g++; end
        repeat (50) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || doneCnt != 0 || gotQ.size() != 5) begin
            miscompares++;
            $display("FAIL reinit_state: got busy=%b done_pulses=%0d words=%0d want 0/0/5", busy, doneCnt, gotQ.size());
        end
        for (int k = 0; k < 5 && k < gotQ.size(); k++) begin
            vectors++;
            if (gotQ[k] !== initWord(k)) begin
                miscompares++;
                $display("FAIL reinit_word%0d: got %h want %h", k, gotQ[k], initWord(k));
            end
        end
    endtask

    task automatic test_bit_timing();
        logic pS, pL, dinRef;
        int hiRun, loRun, ldRun, wordsSeen, dinBad, g;
        rst3 = 1'b0;
        @(negedge clk);
        g = 0;
        while (busy3 === 1'b1 && g < 2000) begin @(negedge clk); g++; end
        vectors++;
        if (g != 495) begin miscompares++; $display("FAIL h3_init_cycles: got %0d want 495", g); end
        rows3 = {$urandom, $urandom};
        @(negedge clk); startN3 = 1'b0;
        @(negedge clk); startN3 = 1'b1;
        pS = 1'b0; pL = 1'b1; dinRef = 1'b0;
        hiRun = 0; loRun = 0; ldRun = 0; wordsSeen = 0; dinBad = 0; g = 0;
        while (done3 !== 1'b1 && g < 5000) begin
            if (sclk3 && !pS) begin
                vectors++;
                if (loRun != 3) begin miscompares++; $display("FAIL h3_sclk_low: got %0d cycles want 3", loRun); end
                loRun = 0;
            end
            if (!sclk3 && pS) begin
                vectors++;
                if (hiRun != 3) begin miscompares++; $display("FAIL h3_sclk_high: got %0d cycles want 3", hiRun); end
                hiRun = 0;
            end
            if (!load3 && pL) begin
                if (wordsSeen > 0) begin
                    vectors++;
                    if (ldRun != 3) begin miscompares++; $display("FAIL h3_load_gap: got %0d cycles want 3", ldRun); end
                end
                wordsSeen++;
            end
            if (load3 && !pL) begin
                vectors++;
                if (dinBad != 0) begin miscompares++; $display("FAIL h3_din_stable: got %0d changes want 0", dinBad); end
                dinBad = 0;
                ldRun = 0;
            end
            if (!load3 && !sclk3 && (pS || pL)) dinRef = din3;
            else if (!load3 && din3 !== dinRef) dinBad++;
            if (sclk3) hiRun++;
            if (!sclk3 && !load3) loRun++;
            if (load3) ldRun++;
            pS = sclk3; pL = load3;
            @(negedge clk); g++;
        end
        vectors++;
        if (done3 !== 1'b1 || wordsSeen != 8 || g != 792) begin
            miscompares++;
            $display("FAIL h3_frame: got done=%b words=%0d cycles=%0d want 1/8/792", done3, wordsSeen, g);
        end
    endtask

    initial begin
        rst3 = 1'b1; startN3 = 1'b1; rows3 = 64'd0;
        test_reset();
        test_frame(64'h55AA_00FF_1824_4281);
        for (int i = 0; i < 3; i++) test_frame({$urandom, $urandom});
        test_snapshot();
        test_back_to_back();
        test_ignore_start();
        test_reset_midframe();
        test_bit_timing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sc_matrix_max7219_scanout.md
# sc_matrix_max7219_scanout

Read-side companion of the row/background registers: snapshots the eight 8-bit row registers that hold the playfield and serializes them to a MAX7219 8x8 LED-matrix driver over its 3-wire serial interface (DIN, SCLK, LOAD). On reset release it sends the driver's configuration sequence once. After that, each `start` request transmits one full frame of eight digit-register writes. It sits between the game datapath (row registers) and the board's matrix connector pins.

## Interface
- `CLKDIV_HALF`, default 4: system clock cycles per SCLK half-period (H). Legal range is ≥1.
- `INTENSITY`, default 4'h8: value written to the intensity register (0x0A) during init.
- `SC_MATRIXSCAN_CLOCK_50`, in, 1: system clock; all logic runs on its rising edge.
- `SC_MATRIXSCAN_RESET_InHigh`, in, 1: asynchronous, active-high reset.
- `SC_MATRIXSCAN_start_InLow`, in, 1: frame request, active low, sampled only in IDLE.
- `SC_MATRIXSCAN_rows_InBUS`, in, 64: row k is on bits [8k+7:8k], with row 0 in the LSBs.
- `SC_MATRIXSCAN_DIN_Out`, out, 1: serial data to the MAX7219, MSB first.
- `SC_MATRIXSCAN_SCLK_Out`, out, 1: serial clock to the MAX7219.
- `SC_MATRIXSCAN_LOAD_Out`, out, 1: MAX7219 LOAD/CS; a word latches on its rising edge.
- `SC_MATRIXSCAN_busy_Out`, out, 1: high while the init sequence or a frame is in progress.
- `SC_MATRIXSCAN_done_Out`, out, 1: one-cycle pulse at the end of each frame. It does not pulse after init.

## Operation
- Word format is 16 bits, {4'h0, addr[3:0], data[7:0]}, sent MSB first.
- Init sequence runs automatically after reset release, with no `start` needed. It sends five words in this order:
  - 0x0C01: shutdown off.
  - 0x0B07: scan limit, 8 digits.
  - 0x0900: no decode.
  - {8'h0A, 4'h0, INTENSITY}: intensity.
  - 0x0F00: display test off.
- Frame sequence: word k (k = 0..7) is {4'h0, k+1, row_k}, taken from the snapshot register.
- Snapshot: all 64 input bits are captured on the clock edge that accepts `start`. Changes to the inputs after that edge do not affect the frame in progress.
- FSM states:
  - INIT_LOW / INIT_HIGH / INIT_GAP: per-bit phases of the init words.
  - IDLE.
  - LOW, HIGH, GAP: per-bit phases of the frame words.
  - Init and frame share one bit-engine. A word counter (0..4 during init, 0..7 during a frame), a bit counter (15..0) and a divider counter (0..H-1) drive it.
- Phase rules:
  - LOW phase, H cycles: SCLK=0, LOAD=0, DIN = current bit.
  - HIGH phase, H cycles: SCLK=1, DIN unchanged.
  - After the HIGH phase of bit 0, the FSM enters GAP for H cycles: SCLK=0, LOAD=1, DIN=0.
  - After GAP, the next word starts, or the FSM returns to IDLE.
- IDLE outputs: SCLK=0, LOAD=1, DIN=0, busy=0.
- `start` is accepted in any IDLE cycle where `start_InLow`=0, including the cycle in which `done` is high.
  - `start` asserted while busy is ignored and is not queued.
  - Holding `start` low produces back-to-back frames separated by exactly one IDLE cycle.
- After INIT completes, the FSM enters IDLE with `done`=0. Until INIT completes, `start` is ignored.

## Timing
- Reset values, applied immediately and asynchronously on assertion:
  - DIN=0, SCLK=0, LOAD=1, busy=0, done=0.
  - Snapshot = 0; all counters = 0; state = INIT_LOW pending.
- First clock edge after reset deasserts: busy=1, LOAD=0, DIN = bit 15 of 0x0C01.
- Word duration is 33H cycles: 16×2H for the bits plus H for the gap.
- Init duration is 165H cycles, all with busy high. IDLE follows.
- Frame timing, with `start` accepted at edge N:
  - From cycle N+1: busy=1, LOAD=0, DIN = bit 15 of word 0.
  - Busy stays high for exactly 264H cycles.
  - At cycle N+1+264H: busy=0 and done=1, for that one cycle only.
- DIN changes only at LOW-phase entry, when SCLK falls or a word starts. This gives H cycles of setup and H cycles of hold around the SCLK rising edge.
- LOAD rises on the same edge on which SCLK falls after bit 0.
- Reset asserted mid-frame or mid-init aborts the transfer with no `done`. Init reruns in full after release.

## Test plan
- Reset release with H=2: the bench decodes DIN on SCLK rising edges and must see 0x0C01, 0x0B07, 0x0900, 0x0A08, 0x0F00. Busy is high for exactly 330 cycles; `done` stays 0.
- Rows 0x81, 0x42, 0x24, 0x18, 0xFF, 0x00, 0xAA, 0x55 with a one-cycle `start` pulse at edge N, H=2:
  - Words are 0x0181, 0x0242, 0x0324, 0x0418, 0x05FF, 0x0600, 0x07AA, 0x0855.
  - `done` pulses at cycle N+529.
- Snapshot: change `rows_InBUS` to all 0x00 during word 2 of a frame. All eight transmitted words must still match the values present at the accepting edge.
- `start` pulsed during init and mid-frame: it is ignored and no extra frame follows. `start` held low: two frames run, with exactly one IDLE cycle (`done`=1) between them.
- Reset asserted during bit 7 of word 3: LOAD=1, SCLK=0, DIN=0 and busy=0 immediately, with no `done`. After release, the full five-word init sequence is sent again.
- Bit timing check with H=3: SCLK is high for 3 and low for 3 cycles, DIN is stable across every SCLK rising edge ±3 cycles, and LOAD is high for 3 cycles between words.
